alu_operand_loader: RTL and testbench
=====================================

// Module: alu_operand_loader
// PURPOSE
//  Upstream stage of the N-bit logic unit. Collects operand A, operand B and
//  the operation select one after another from the board switches on a load
//  strobe. Holds all three in registers and presents them with a valid flag
//  until the consumer acknowledges. Also counts completed operand sets for
//  display.
// PARAMETERS
//  N    2  operand width; a/b/sw width, must match the logic unit's N
//  OPW  2  width of operation select (AND/OR/XOR/NOT encodings live downstream)
//  CW   4  width of completed-set counter
// PORTS
//  clk      in   1    system clock, all state updates on rising edge
//  rst_n    in   1    synchronous active-low reset
//  sw       in   N    operand value from switches (already synchronised)
//  op_in    in   OPW  operation select from switches (already synchronised)
//  load     in   1    debounced load button, level; block edge-detects it
//  clear    in   1    synchronous abort/clear, active-high
//  ack      in   1    consumer has taken current operand set
//  a        out  N    registered operand A to logic unit
//  b        out  N    registered operand B to logic unit
//  op       out  OPW  registered operation select
//  valid    out  1    a/b/op form a complete set
//  phase    out  2    current FSM state encoding (for LEDs)
//  set_cnt  out  CW   number of completed sets, wraps modulo 2**CW
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - a=0, b=0, op=0, valid=0, set_cnt=0, phase=LOAD_A.
//   - load_q=1, so a load held high through reset gives no spurious edge.
//  Edge detect: ld_edge = load & ~load_q; load_q <= load every cycle.
//   - One capture per press regardless of press length.
//  FSM, phase encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3.
//   - LOAD_A:  ld_edge -> a<=sw, go LOAD_B.
//   - LOAD_B:  ld_edge -> b<=sw, go LOAD_OP.
//   - LOAD_OP: ld_edge -> op<=op_in, set_cnt<=set_cnt+1, valid<=1, go READY.
//   - READY:
//     - ack alone -> valid<=0, go LOAD_A; a/b/op keep their values.
//     - ld_edge (with or without ack) -> valid<=0, a<=sw, go LOAD_B.
//   - ack outside READY is ignored.
//   - ld_edge with no state change is never lost: every edge advances the FSM.
//  Latency: every output is registered; captured value is visible the cycle
//   after the capturing edge. valid rises in the same cycle op updates.
//  clear: highest priority after reset, including over a same-cycle ld_edge.
//   - Forces a=b=op=0, valid=0, phase=LOAD_A; set_cnt is kept.
//   - load_q still updates normally.
//  set_cnt wraps from 2**CW-1 to 0 with no flag.
//  Reset or clear mid-sequence (LOAD_B/LOAD_OP) discards the partial set.
//  Outputs never glitch. a/b/op change only on capture, clear or reset.
// TESTING
//  1 Reset with load held 1, release rst_n -> no capture; phase=0, a=b=op=0,
//    valid=0.
//  2 N=2: sw=2'b10, press; sw=2'b11, press; op_in=2'b01, press.
//    -> a=10, b=11, op=01, valid=1, phase=3, set_cnt=1.
//  3 In READY assert ack 1 cycle -> next cycle valid=0, phase=0, a=10 held.
//    Ack in LOAD_B has no effect.
//  4 Hold load high 20 cycles in LOAD_A -> exactly one capture, phase=1.
//  5 In LOAD_OP, assert clear and press load in the same cycle.
//    -> phase=0, a=b=op=0, set_cnt unchanged.
//  6 In READY press load with sw=01 and ack=1 -> valid=0, a=01, phase=1.
//    Complete 2**CW sets -> set_cnt returns to 0.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Operand loader ahead of the N-bit logic unit: captures A, B and the op
// select from switches on successive load presses and holds them until acked.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   sw [N-1:0]        operand value from switches
//   op_in [OPW-1:0]   operation select from switches
//   load              debounced load button level (edge-detected here)
//   clear             synchronous abort, discards the current set
//   ack               consumer took the current set
//   a, b, op          registered operand set
//   valid             a/b/op form a complete set
//   phase [1:0]       FSM state for LEDs (0=A, 1=B, 2=OP, 3=READY)
//   set_cnt [CW-1:0]  completed sets, wraps silently
module alu_operand_loader #(
    parameter int N   = 2,
    parameter int OPW = 2,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   sw,
    input  logic [OPW-1:0] op_in,
    input  logic           load,
    input  logic           clear,
    input  logic           ack,
    output logic [N-1:0]   a,
    output logic [N-1:0]   b,
    output logic [OPW-1:0] op,
    output logic           valid,
    output logic [1:0]     phase,
    output logic [CW-1:0]  set_cnt
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           load_q;
    logic           ld_edge;

    assign ld_edge = load & ~load_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (ld_edge) begin
                        a_d     = sw;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (ld_edge) begin
                        b_d     = sw;
                        state_d = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (ld_edge) begin
                        op_d    = op_in;
                        cnt_d   = cnt_q + 1'b1;
                        valid_d = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    // A new press starts the next set directly, so it
                    // takes precedence over a simultaneous ack.
                    if (ld_edge) begin
                        valid_d = 1'b0;
                        a_d     = sw;
                        state_d = LOAD_B;
                    end else if (ack) begin
                        valid_d = 1'b0;
                        state_d = LOAD_A;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            // Treat load as already high so a press held through
            // reset does not capture on release.
            load_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            load_q  <= load;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign op      = op_q;
    assign valid   = valid_q;
    assign phase   = state_q;
    assign set_cnt = cnt_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios plus random traffic,
// all outputs compared each cycle against a behavioural reference.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw;
    logic [1:0] op_in;
    logic       load;
    logic       clear;
    logic       ack;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       valid;
    logic [1:0] phase;
    logic [3:0] set_cnt;

    int checks   = 0;
    int failures = 0;

    // reference state
    int m_a, m_b, m_op, m_phase, m_cnt;
    bit m_valid, m_prev;

    alu_operand_loader #(.N(2), .OPW(2), .CW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .op_in   (op_in),
        .load    (load),
        .clear   (clear),
        .ack     (ack),
        .a       (a),
        .b       (b),
        .op      (op),
        .valid   (valid),
        .phase   (phase),
        .set_cnt (set_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the slot a new press fills is the phase number;
    // the set completes on the third press and wraps the counter.
    task automatic model_edge();
        bit press;
        press  = load && !m_prev;
        m_prev = load;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0; m_valid = 0;
            m_phase = 0; m_cnt = 0; m_prev = 1;
        end else if (clear) begin
            m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_phase = 0;
        end else if (press) begin
            if (m_phase == 0 || m_phase == 3) begin
                m_a = sw; m_valid = 0; m_phase = 1;
            end else if (m_phase == 1) begin
                m_b = sw; m_phase = 2;
            end else begin
                m_op = op_in; m_valid = 1; m_phase = 3;
                m_cnt = (m_cnt + 1) % 16;
            end
        end else if (ack && m_phase == 3) begin
            m_valid = 0; m_phase = 0;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic l, input logic [1:0] s,
                        input logic [1:0] o, input logic c,
                        input logic k);
        load = l; sw = s; op_in = o; clear = c; ack = k;
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        assert ({a, b, op, valid, phase, set_cnt} ===
                {2'(m_a), 2'(m_b), 2'(m_op), m_valid,
                 2'(m_phase), 4'(m_cnt)})
        else begin
            failures++;
            $error("FAIL model a=%0d b=%0d op=%0d v=%0d ph=%0d cnt=%0d exp a=%0d b=%0d op=%0d v=%0d ph=%0d cnt=%0d",
                   a, b, op, valid, phase, set_cnt,
                   m_a, m_b, m_op, m_valid, m_phase, m_cnt);
        end
    endtask

    task automatic press(input logic [1:0] s, input logic [1:0] o);
        step(1'b1, s, o, 1'b0, 1'b0);
        step(1'b0, s, o, 1'b0, 1'b0);
    endtask

    initial begin
        m_prev = 1;
        m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_phase = 0; m_cnt = 0;
        // 1: reset with load held, then release with load still high
        rst_n = 1'b0;
        step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("reset_phase", phase, 0);
        chk("reset_a", a, 0);
        chk("reset_valid", valid, 0);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // 2: full set
        press(2'b10, 2'b00);
        press(2'b11, 2'b00);
        press(2'b00, 2'b01);
        chk("set_a", a, 2);
        chk("set_b", b, 3);
        chk("set_op", op, 1);
        chk("set_valid", valid, 1);
        chk("set_phase", phase, 3);
        chk("set_cnt1", set_cnt, 1);

        // 3: ack in READY
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        chk("ack_valid", valid, 0);
        chk("ack_phase", phase, 0);
        chk("ack_a_held", a, 2);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        // 4: long press captures once
        for (int i = 0; i < 20; i++)
            step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b01, 2'b00, 1'b0, 1'b0);
        chk("long_phase", phase, 1);
        chk("long_a", a, 1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        chk("ack_ignored", phase, 1);

        // 5: clear wins over a same-cycle press in LOAD_OP
        press(2'b10, 2'b00);
        chk("pre_clear_phase", phase, 2);
        step(1'b1, 2'b11, 2'b11, 1'b1, 1'b0);
        step(1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        chk("clr_phase", phase, 0);
        chk("clr_ab", {a, b, op}, 0);
        chk("clr_cnt", set_cnt, 1);

        // 6: press+ack in READY, then wrap the counter
        press(2'b11, 2'b00);
        press(2'b10, 2'b00);
        press(2'b00, 2'b10);
        chk("rdy_cnt", set_cnt, 2);
        step(1'b1, 2'b01, 2'b00, 1'b0, 1'b1);
        chk("rdy_press_valid", valid, 0);
        chk("rdy_press_a", a, 1);
        chk("rdy_press_phase", phase, 1);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        press(2'b01, 2'b00);
        press(2'b00, 2'b11);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
            press(2'(i), 2'b00);
            press(2'(i + 1), 2'b00);
            press(2'b00, 2'(i + 2));
        end
        chk("wrap_cnt", set_cnt, 0);
        chk("wrap_valid", valid, 1);

        // random traffic against the reference
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step(1'($urandom_range(0, 1)), 2'($urandom),
                 2'($urandom), ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)));
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
